// File: rtl/puf_voter_pkg.sv
// puf_voter_pkg: shared FSM encoding, datapath widths and parameter limits for the PUF majority voter.
package puf_voter_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, WAIT, SAMPLE} state_t;
  localparam int CNT_W       = 4;
  localparam int TIMER_W     = 8;
  localparam int MIN_SAMPLES = 3;
  localparam int MAX_SAMPLES = 15;
  localparam int MIN_SETTLE  = 1;
  localparam int MAX_SETTLE  = 255;
endpackage

// File: rtl/puf_bit_counter.sv
// puf_bit_counter: counts ones seen on one response bit and flags majority/unanimity of the final count.
module puf_bit_counter
  import puf_voter_pkg::*;
#(
  parameter int NUM_SAMPLES = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc_en,
  input  logic bit_in,
  output logic majority,
  output logic unanimous
);
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;
  // Flags look at the count including the bit being sampled this cycle.
  assign next_count = count + CNT_W'(inc_en & bit_in);
  assign majority   = next_count > CNT_W'(NUM_SAMPLES / 2);
  assign unanimous  = (next_count == '0) || (next_count == CNT_W'(NUM_SAMPLES));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else count <= clr ? '0 : next_count;
  end
endmodule

// File: rtl/puf_majority_voter.sv
// puf_majority_voter: fires the PUF NUM_SAMPLES times per request and reports a per-bit majority vote and instability mask.
module puf_majority_voter
  import puf_voter_pkg::*;
#(
  parameter int NUM_SAMPLES   = 7,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [3:0] req_addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] vote_out,
  output logic [7:0] unstable_mask,
  output logic       puf_start,
  output logic [3:0] puf_addr,
  input  logic [7:0] puf_data
);
  if (NUM_SAMPLES < MIN_SAMPLES || NUM_SAMPLES > MAX_SAMPLES || NUM_SAMPLES % 2 == 0) begin : g_bad_samples
    $fatal(1, "NUM_SAMPLES must be odd and within 3..15");
  end
  if (SETTLE_CYCLES < MIN_SETTLE || SETTLE_CYCLES > MAX_SETTLE) begin : g_bad_settle
    $fatal(1, "SETTLE_CYCLES must be within 1..255");
  end
  state_t             state;
  state_t             next_state;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   sample_idx;
  logic [7:0]         majority;
  logic [7:0]         unanimous;
  logic               last_sample;
  logic               clr;
  logic               inc_en;
  assign last_sample = sample_idx == CNT_W'(NUM_SAMPLES - 1);
  assign clr         = (state == IDLE) && req;
  assign inc_en      = state == SAMPLE;
  for (genvar i = 0; i < 8; i++) begin : g_bit
    puf_bit_counter #(.NUM_SAMPLES(NUM_SAMPLES)) u_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .clr(clr),
      .inc_en(inc_en),
      .bit_in(puf_data[i]),
      .majority(majority[i]),
      .unanimous(unanimous[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  end
  // WAIT leaves on the edge whose decrement brings the timer to zero.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = req ? PULSE : IDLE;
      PULSE:   next_state = WAIT;
      WAIT:    next_state = (timer == TIMER_W'(1)) ? SAMPLE : WAIT;
      SAMPLE:  next_state = last_sample ? IDLE : PULSE;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    busy      = state != IDLE;
    puf_start = state == PULSE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done          <= 1'b0;
      vote_out      <= '0;
      unstable_mask <= '0;
      puf_addr      <= '0;
      timer         <= '0;
      sample_idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req) begin
          puf_addr   <= req_addr;
          sample_idx <= '0;
        end
        PULSE: timer <= TIMER_W'(SETTLE_CYCLES);
        WAIT:  timer <= timer - TIMER_W'(1);
        SAMPLE: if (last_sample) begin
          vote_out      <= majority;
          unstable_mask <= ~unanimous;
          done          <= 1'b1;
        end else sample_idx <= sample_idx + CNT_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_majority_voter.sv
// tb_puf_majority_voter: randomized scoreboard bench for two voter configurations (7/4 and 3/1).
module tb_puf_majority_voter;
  typedef struct {
    logic [7:0] v;
    logic [7:0] m;
    int         dc;
  } exp_t;
  logic       clk;
  logic       rst_n;
  logic       req[2];
  logic [3:0] req_addr[2];
  logic       busy[2];
  logic       done[2];
  logic [7:0] vote_out[2];
  logic [7:0] unstable_mask[2];
  logic       puf_start[2];
  logic [3:0] puf_addr[2];
  logic [7:0] puf_data[2];
  logic [7:0] pat[2][16];
  logic [3:0] cur_addr[2];
  int         k[2];
  int         last_start[2];
  int         cyc = 0;
  int         pass = 0;
  int         total = 0;
  exp_t       q0[$];
  exp_t       q1[$];
  puf_majority_voter #(.NUM_SAMPLES(7), .SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .req_addr(req_addr[0]), .busy(busy[0]), .done(done[0]),
    .vote_out(vote_out[0]), .unstable_mask(unstable_mask[0]), .puf_start(puf_start[0]),
    .puf_addr(puf_addr[0]), .puf_data(puf_data[0])
  );
  puf_majority_voter #(.NUM_SAMPLES(3), .SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .req_addr(req_addr[1]), .busy(busy[1]), .done(done[1]),
    .vote_out(vote_out[1]), .unstable_mask(unstable_mask[1]), .puf_start(puf_start[1]),
    .puf_addr(puf_addr[1]), .puf_data(puf_data[1])
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic int ns(int i);
    return i == 0 ? 7 : 3;
  endfunction
  function automatic int st(int i);
    return i == 0 ? 4 : 1;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  // Reference: count ones per bit over the requested samples, then vote.
  function automatic exp_t model(int i, int acc);
    exp_t r;
    int   c;
    r.v = '0;
    r.m = '0;
    for (int b = 0; b < 8; b++) begin
      c = 0;
      for (int s = 0; s < ns(i); s++) c += int'(pat[i][s][b]);
      r.v[b] = 2 * c > ns(i);
      r.m[b] = c != 0 && c != ns(i);
    end
    r.dc = acc + ns(i) * (st(i) + 2);
    return r;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_mon
    exp_t e;
    always @(negedge clk) if (rst_n) begin
      if (puf_start[g]) begin
        if (k[g] > 0) chk("start_gap", cyc - last_start[g], st(g) + 2);
        chk("puf_addr", puf_addr[g], cur_addr[g]);
        last_start[g] = cyc;
        puf_data[g] = pat[g][k[g]];
        k[g]++;
      end
      if (done[g]) begin
        if ((g == 0 ? q0.size() : q1.size()) == 0) chk("unexpected_done", done[g], 0);
        else begin
          e = (g == 0) ? q0.pop_front() : q1.pop_front();
          chk("vote_out", vote_out[g], e.v);
          chk("unstable_mask", unstable_mask[g], e.m);
          chk("done_cycle", cyc, e.dc);
          chk("busy_at_done", busy[g], 0);
          chk("pulse_count", k[g], ns(g));
        end
        k[g] = 0;
      end
    end
  end
  task automatic start(int i, logic [3:0] a, bit hold);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_req", busy[i], 0);
    cur_addr[i] = a;
    req_addr[i] = a;
    req[i] = 1'b1;
    k[i] = 0;
    e = model(i, cyc + 1);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
    if (hold) begin
      e = model(i, e.dc + 1);
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end else begin
      @(negedge clk);
      req[i] = 1'b0;
    end
  endtask
  task automatic wait_done(int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[i] && n < 400);
    chk("done_timeout", done[i], 1);
  endtask
  task automatic fill(int i, logic [7:0] v);
    for (int s = 0; s < 16; s++) pat[i][s] = v;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0;
      req_addr[i] = '0;
      puf_data[i] = '0;
      cur_addr[i] = '0;
      k[i] = 0;
      last_start[i] = 0;
      fill(i, 8'h00);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_start", puf_start[0], 0);
    chk("rst_vote", vote_out[0], 0);
    chk("rst_mask", unstable_mask[0], 0);
    chk("rst_addr", puf_addr[0], 0);
    rst_n = 1'b1;
    fill(0, 8'hA5);
    start(0, 4'd3, 1'b0);
    wait_done(0);
    chk("const_vote", vote_out[0], 8'hA5);
    chk("const_mask", unstable_mask[0], 8'h00);
    fill(0, 8'h00);
    for (int s = 0; s < 3; s++) pat[0][s] = 8'h03;
    pat[0][3] = 8'h01;
    start(0, 4'd11, 1'b0);
    wait_done(0);
    chk("noisy_vote", vote_out[0], 8'h01);
    chk("noisy_mask", unstable_mask[0], 8'h03);
    fill(0, 8'h00);
    start(0, 4'd0, 1'b0);
    wait_done(0);
    fill(0, 8'hFF);
    start(0, 4'd15, 1'b0);
    wait_done(0);
    chk("ones_vote", vote_out[0], 8'hFF);
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 7; s++) pat[0][s] = 8'($urandom);
      start(0, 4'($urandom), 1'b0);
      wait_done(0);
    end
    for (int s = 0; s < 7; s++) pat[0][s] = 8'($urandom);
    start(0, 4'd2, 1'b0);
    repeat (9) @(negedge clk);
    req_addr[0] = 4'd9;
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    req_addr[0] = 4'd2;
    chk("ignored_req_addr", puf_addr[0], 4'd2);
    wait_done(0);
    for (int s = 0; s < 7; s++) pat[0][s] = 8'($urandom);
    start(0, 4'd12, 1'b1);
    wait_done(0);
    wait_done(0);
    req[0] = 1'b0;
    fill(0, 8'h3C);
    start(0, 4'd6, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy[0], 0);
    chk("abort_start", puf_start[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_vote", vote_out[0], 0);
    chk("abort_mask", unstable_mask[0], 0);
    chk("abort_addr", puf_addr[0], 0);
    q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k[0] = 0;
    for (int s = 0; s < 7; s++) pat[0][s] = 8'($urandom);
    start(0, 4'd5, 1'b0);
    wait_done(0);
    pat[1][0] = 8'hFF;
    pat[1][1] = 8'hFF;
    pat[1][2] = 8'h00;
    start(1, 4'd7, 1'b0);
    wait_done(1);
    chk("small_vote", vote_out[1], 8'hFF);
    chk("small_mask", unstable_mask[1], 8'hFF);
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 3; s++) pat[1][s] = 8'($urandom);
      start(1, 4'($urandom), 1'b0);
      wait_done(1);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
